// File: rtl/tb_pkg.sv
// Shared sizing helpers and the wide token-count type used by token_bucket and its scoreboard.
package tb_pkg;

  localparam int TOK_CNT_W = 16;

  // Wide enough for any supported DEPTH+REFILL_AMT sum.
  typedef logic [TOK_CNT_W-1:0] tok_cnt_t;

  function automatic int clog2_min1(input int x);
    return ($clog2(x) < 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/tb_refill_timer.sv
// Free-running 0..PERIOD-1 counter; tick_o is high during the last count of each period.
// Latency: first tick is seen on the PERIOD-th edge after reset release; no backpressure.
module tb_refill_timer
  import tb_pkg::*;
#(
  parameter int PERIOD = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int CNT_W = clog2_min1(PERIOD);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == CNT_W'(PERIOD - 1));
  assign cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/token_bucket.sv
// Token-bucket rate limiter on rising edges of evt_i: grant if a token is held, else queue up to PEND_MAX, else drop.
// Latency: grant_o/drop_o pulse one edge after the deciding cycle; no backpressure, excess requests are queued or dropped.
module token_bucket
  import tb_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int REFILL_PERIOD = 8,
  parameter int REFILL_AMT    = 1,
  parameter int PEND_MAX      = 2,
  parameter int INIT_FULL     = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  evt_i,
  output logic                                  grant_o,
  output logic                                  drop_o,
  output logic [clog2_min1(DEPTH+1)-1:0]        tokens_o,
  output logic [clog2_min1(PEND_MAX+1)-1:0]     pend_o,
  output logic                                  empty_o
);

  localparam int TOK_W  = clog2_min1(DEPTH + 1);
  localparam int PEND_W = clog2_min1(PEND_MAX + 1);
  localparam int SUM_W  = clog2_min1(DEPTH + REFILL_AMT + 1);

  if (DEPTH < 1 || REFILL_PERIOD < 1 || REFILL_AMT < 1 || REFILL_AMT > DEPTH ||
      PEND_MAX < 0 || SUM_W > $bits(tok_cnt_t)) begin : g_bad_param
    $error("token_bucket: illegal DEPTH/REFILL_PERIOD/REFILL_AMT/PEND_MAX");
  end

  logic              tick;
  logic              evt_q;
  logic [TOK_W-1:0]  tok_q,   tok_d;
  logic [PEND_W-1:0] pend_q,  pend_d;
  logic              grant_q, grant_d;
  logic              drop_q,  drop_d;
  logic              consume;
  logic              rise;
  logic              has_tok;
  logic              pend_nz;
  logic              pend_full;
  logic [SUM_W-1:0]  tok_sum;

  tb_refill_timer #(
    .PERIOD (REFILL_PERIOD)
  ) u_refill_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  assign rise      = evt_i & ~evt_q;
  assign has_tok   = (tok_q != '0);
  assign pend_nz   = (pend_q != '0);
  assign pend_full = (pend_q >= PEND_W'(PEND_MAX));

  // Queued requests always take the token ahead of a fresh edge.
  always_comb begin
    consume = 1'b0;
    grant_d = 1'b0;
    drop_d  = 1'b0;
    pend_d  = pend_q;
    if (pend_nz && has_tok) begin
      consume = 1'b1;
      grant_d = 1'b1;
      if (!rise) begin
        pend_d = pend_q - PEND_W'(1);
      end
    end else if (rise && has_tok) begin
      consume = 1'b1;
      grant_d = 1'b1;
    end else if (rise && !pend_full) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (rise) begin
      drop_d = 1'b1;
    end
  end

  always_comb begin
    tok_sum = SUM_W'(tok_q) - SUM_W'(consume) + (tick ? SUM_W'(REFILL_AMT) : '0);
    tok_d   = (tok_sum > SUM_W'(DEPTH)) ? TOK_W'(DEPTH) : tok_sum[TOK_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q   <= 1'b0;
      tok_q   <= (INIT_FULL != 0) ? TOK_W'(DEPTH) : '0;
      pend_q  <= '0;
      grant_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      evt_q   <= evt_i;
      tok_q   <= tok_d;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      drop_q  <= drop_d;
    end
  end

  assign grant_o  = grant_q;
  assign drop_o   = drop_q;
  assign tokens_o = tok_q;
  assign pend_o   = pend_q;
  assign empty_o  = (tok_q == '0);

endmodule

// File: tb/tb_token_bucket.sv
// Self-checking bench for token_bucket with default parameters: vector table, directed sequences, scoreboard model.
module tb_token_bucket;
  import tb_pkg::*;

  localparam int DEPTH     = 4;
  localparam int PERIOD    = 8;
  localparam int AMT       = 1;
  localparam int PEND_MAX  = 2;
  localparam int INIT_FULL = 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       evt_i = 1'b0;
  logic       grant_o;
  logic       drop_o;
  logic [2:0] tokens_o;
  logic [1:0] pend_o;
  logic       empty_o;

  token_bucket #(
    .DEPTH         (DEPTH),
    .REFILL_PERIOD (PERIOD),
    .REFILL_AMT    (AMT),
    .PEND_MAX      (PEND_MAX),
    .INIT_FULL     (INIT_FULL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .evt_i    (evt_i),
    .grant_o  (grant_o),
    .drop_o   (drop_o),
    .tokens_o (tokens_o),
    .pend_o   (pend_o),
    .empty_o  (empty_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       g;
    bit       d;
    tok_cnt_t tok;
    int       pend;
  } exp_t;

  typedef struct {
    bit evt;
    bit g;
    bit d;
    int tok;
    int pend;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_grant = 0;
  int   n_drop  = 0;
  int   n_rise  = 0;
  int   m_tok, m_pend, m_cnt;
  bit   m_evt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_tok  = (INIT_FULL != 0) ? DEPTH : 0;
    m_pend = 0;
    m_cnt  = 0;
    m_evt  = 1'b0;
    sb.delete();
  endtask

  // Reference: waiting requests form one line; a token serves its head, overflow beyond PEND_MAX is dropped.
  task automatic model_step(input bit e, output exp_t x);
    bit rise;
    int waiting;
    int take;
    rise    = e && !m_evt;
    waiting = m_pend + (rise ? 1 : 0);
    take    = 0;
    x.g     = 1'b0;
    x.d     = 1'b0;
    if (rise) n_rise++;
    if (m_tok > 0 && waiting > 0) begin
      take    = 1;
      x.g     = 1'b1;
      waiting = waiting - 1;
    end
    if (waiting > PEND_MAX) begin
      x.d     = 1'b1;
      waiting = PEND_MAX;
    end
    m_pend = waiting;
    m_tok  = m_tok - take + ((m_cnt == PERIOD - 1) ? AMT : 0);
    if (m_tok > DEPTH) m_tok = DEPTH;
    m_cnt  = (m_cnt + 1) % PERIOD;
    m_evt  = e;
    x.tok  = tok_cnt_t'(m_tok);
    x.pend = m_pend;
  endtask

  task automatic step(input bit e, input string tag);
    exp_t x;
    exp_t y;
    evt_i = e;
    model_step(e, x);
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    y = sb.pop_front();
    chk($sformatf("%s.grant", tag), 32'(grant_o), 32'(y.g));
    chk($sformatf("%s.drop", tag), 32'(drop_o), 32'(y.d));
    chk($sformatf("%s.tokens", tag), 32'(tokens_o), 32'(y.tok));
    chk($sformatf("%s.pend", tag), 32'(pend_o), 32'(y.pend));
    chk($sformatf("%s.empty", tag), 32'(empty_o), 32'(y.tok == 0));
    chk($sformatf("%s.tok_le_depth", tag), 32'(tokens_o <= 3'(DEPTH)), 32'(1));
    n_grant += int'(grant_o);
    n_drop  += int'(drop_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   g0, d0, r0, gq, inc;
    logic [2:0] prev_tok;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 3, 0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 3, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 2, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 2, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1, 0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1, 0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 0, 0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1, 0};

    // Power-on reset held for 5 cycles.
    rst_n = 1'b0;
    evt_i = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset.tokens", 32'(tokens_o), 32'(4));
    chk("reset.pend", 32'(pend_o), 32'(0));
    chk("reset.grant", 32'(grant_o), 32'(0));
    chk("reset.drop", 32'(drop_o), 32'(0));
    chk("reset.empty", 32'(empty_o), 32'(0));
    rst_n = 1'b1;

    // Four isolated pulses before the first refill, then the first tick.
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].evt, $sformatf("dir%0d", i));
      chk($sformatf("vec%0d.grant", i), 32'(grant_o), 32'(tbl[i].g));
      chk($sformatf("vec%0d.drop", i), 32'(drop_o), 32'(tbl[i].d));
      chk($sformatf("vec%0d.tokens", i), 32'(tokens_o), 32'(tbl[i].tok));
      chk($sformatf("vec%0d.pend", i), 32'(pend_o), 32'(tbl[i].pend));
    end

    // Empty the bucket, then queue two and drop the third.
    step(1'b1, "q.take");
    chk("q.tokens0", 32'(tokens_o), 32'(0));
    step(1'b0, "q");
    step(1'b1, "q.r1");
    chk("q.pend1", 32'(pend_o), 32'(1));
    step(1'b0, "q");
    step(1'b1, "q.r2");
    chk("q.pend2", 32'(pend_o), 32'(2));
    step(1'b0, "q");
    step(1'b1, "q.r3");
    chk("q.drop", 32'(drop_o), 32'(1));
    chk("q.pend_after_drop", 32'(pend_o), 32'(2));
    gq = 0;
    for (int i = 0; i < 20 && gq < 2; i++) begin
      step(1'b0, "q.drain");
      if (grant_o) begin
        gq++;
        chk("q.grant_pend", 32'(pend_o), 32'(2 - gq));
        chk("q.grant_tokens", 32'(tokens_o), 32'(0));
      end
    end
    chk("q.grants", 32'(gq), 32'(2));

    // Idle refill from empty: +1 every period, saturating at DEPTH.
    chk("idle.start", 32'(tokens_o), 32'(0));
    inc = 0;
    for (int i = 0; i < 40; i++) begin
      prev_tok = tokens_o;
      step(1'b0, "idle");
      if (tokens_o != prev_tok) inc++;
    end
    chk("idle.increments", 32'(inc), 32'(4));
    chk("idle.final", 32'(tokens_o), 32'(4));

    // A held level is one request; six-cycle pulses are one request each.
    g0 = n_grant;
    step(1'b1, "hold");
    chk("hold.first_tokens", 32'(tokens_o), 32'(3));
    repeat (19) step(1'b1, "hold");
    chk("hold.grants", 32'(n_grant - g0), 32'(1));
    step(1'b0, "hold");
    g0 = n_grant;
    for (int p = 0; p < 3; p++) begin
      repeat (6) step(1'b1, "pulse");
      step(1'b0, "pulse");
    end
    chk("pulse.grants", 32'(n_grant - g0), 32'(3));

    // Random request stream: every request is granted, dropped or still queued.
    g0 = n_grant;
    d0 = n_drop;
    r0 = n_rise;
    for (int i = 0; i < 500; i++) begin
      step(bit'($urandom_range(0, 1)), "rand");
    end
    chk("rand.conserve", 32'((n_grant - g0) + (n_drop - d0) + int'(pend_o)), 32'(n_rise - r0));

    // Asynchronous reset between edges with requests queued.
    step(1'b0, "ar");
    for (int i = 0; i < 30; i++) begin
      step(1'b1, "ar.fill");
      if (pend_o != 2'd0) break;
      step(1'b0, "ar.fill");
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.tokens", 32'(tokens_o), 32'(4));
    chk("areset.pend", 32'(pend_o), 32'(0));
    chk("areset.grant", 32'(grant_o), 32'(0));
    chk("areset.drop", 32'(drop_o), 32'(0));
    chk("areset.empty", 32'(empty_o), 32'(0));
    evt_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("areset.held_drop", 32'(drop_o), 32'(0));
    rst_n = 1'b1;
    step(1'b1, "post");
    chk("post.grant", 32'(grant_o), 32'(1));
    step(1'b0, "post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
